call_return_ctrl: RTL and testbench
===================================

// Module: call_return_ctrl
// PURPOSE
//  Call/return sequencer sitting directly upstream of function_stack storage. Takes call/ret
//  strobes from decode, maintains the stack pointer, writes return addresses (pc+1) on call,
//  reads the top entry on ret and issues a one-cycle redirect to fetch. Stalls decode while a
//  return is in flight; flags overflow/underflow without corrupting state.
// PARAMETERS
//  IA_WIDTH   12  instruction address width (return address width)
//  DEPTH      16  number of stack entries
//  SP_WIDTH   $clog2(DEPTH+1)  stack pointer width (must hold 0..DEPTH)
// PORTS
//  clk              in   1         system clock, all state on rising edge
//  rst_n            in   1         asynchronous active-low reset
//  call_i           in   1         decode: call instruction this cycle
//  ret_i            in   1         decode: return instruction this cycle
//  pc_i             in   IA_WIDTH  address of the call instruction
//  clear_err_i      in   1         clears sticky error flags
//  mem_we_o         out  1         stack memory write enable
//  mem_addr_o       out  SP_WIDTH-1 stack memory address (entry index)
//  mem_din_o        out  IA_WIDTH  stack memory write data
//  mem_dout_i       in   IA_WIDTH  stack memory read data, valid 1 cycle after address
//  redirect_valid_o out  1         one-cycle pulse: fetch must jump to redirect_addr_o
//  redirect_addr_o  out  IA_WIDTH  return target
//  stall_o          out  1         decode must hold; call_i/ret_i ignored while high
//  overflow_o       out  1         sticky: call attempted with stack full
//  underflow_o      out  1         sticky: ret attempted with stack empty
//  depth_o          out  SP_WIDTH  current entry count (= sp)
// BEHAVIOUR
//  - Reset (async, rst_n=0): sp=0, state IDLE, all outputs 0; memory contents not cleared.
//  - FSM states: IDLE, RD_WAIT. IDLE->RD_WAIT on accepted ret; RD_WAIT->IDLE unconditionally.
//  - Call (IDLE, call_i=1, ret_i=0): if sp<DEPTH: mem_we_o=1, mem_addr_o=sp,
//    mem_din_o=pc_i+1 (modulo 2^IA_WIDTH, 12'hFFF wraps to 0), sp<=sp+1 next edge.
//    if sp==DEPTH: no write, sp unchanged, overflow_o<=1.
//  - Ret (IDLE, ret_i=1, call_i=0): if sp>0: mem_we_o=0, mem_addr_o=sp-1, sp<=sp-1,
//    stall_o=1 combinationally this cycle, go RD_WAIT. if sp==0: underflow_o<=1, no redirect,
//    no stall, stay IDLE.
//  - RD_WAIT: redirect_valid_o=1, redirect_addr_o=mem_dout_i, stall_o=1; exactly one cycle.
//    Return latency: ret accepted in cycle N -> redirect pulse in cycle N+1.
//  - call_i and ret_i both high in IDLE: illegal; neither executes, sp unchanged,
//    overflow_o<=1 and underflow_o<=1 (protocol error signature).
//  - Any call_i/ret_i during RD_WAIT ignored (stall_o already high).
//  - mem_we_o only ever high in IDLE with a legal call; never in RD_WAIT.
//  - clear_err_i clears both flags next edge; a new error in the same cycle wins (set).
//  - Outside an accepted call/ret, mem_addr_o=sp-1 (0 when empty), mem_din_o=0.
//  - Reset mid-RD_WAIT: pulse suppressed, state IDLE, sp=0.
// STRUCTURE
//  - callstk_pkg: typedef enum logic {IDLE, RD_WAIT} callstk_state_t; localparam defaults
//    for IA_WIDTH/DEPTH shared with function_stack and decode.
//  - One sub-module: callstk_sp -- up/down stack-pointer counter with full/empty outputs,
//    inc/dec inputs, async active-low reset. FSM, error flags and mem muxing stay in top.
// TESTING
//  - Reset then call pc=12'h010 -> mem_we_o=1 addr 0 din 12'h011; depth_o=1 next cycle.
//  - Calls pc=0x010,0x020 then ret -> cycle N stall_o=1 addr 1; N+1 redirect_valid_o=1
//    addr 12'h021, stall_o=1; N+2 stall_o=0, depth_o=1.
//  - DEPTH calls then one more call -> no mem_we_o, depth_o=DEPTH, overflow_o=1;
//    clear_err_i -> overflow_o=0.
//  - Ret with depth 0 -> underflow_o=1, redirect_valid_o stays 0, stall_o=0.
//  - call_i=ret_i=1 at depth 3 -> depth stays 3, both flags set, no write, no redirect.
//  - Call pc=12'hFFF -> din 12'h000; ret then rst_n low during RD_WAIT -> no redirect pulse,
//    depth_o=0, all outputs 0.

Source files
------------

// File: rtl/callstk_pkg.sv
// Shared call-stack definitions: FSM state encoding and default geometry
// used by call_return_ctrl, function_stack and decode.
package callstk_pkg;

    typedef enum logic {IDLE, RD_WAIT} callstk_state_t;

    localparam int unsigned IA_WIDTH_DEF = 12;
    localparam int unsigned DEPTH_DEF    = 16;

endpackage

// File: rtl/callstk_sp.sv
// Up/down stack-pointer counter for the call stack; holds 0..DEPTH and
// reports full/empty so the controller can gate push/pop.
module callstk_sp #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SP_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [SP_WIDTH-1:0] sp_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam logic [SP_WIDTH-1:0] SP_ONE  = SP_WIDTH'(1);
    localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(DEPTH);

    logic [SP_WIDTH-1:0] r_sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (inc_i && !full_o) begin
            r_sp <= r_sp + SP_ONE;
        end else if (dec_i && !empty_o) begin
            r_sp <= r_sp - SP_ONE;
        end
    end

    assign sp_o    = r_sp;
    assign full_o  = (r_sp == SP_FULL);
    assign empty_o = (r_sp == '0);

endmodule

// File: rtl/call_return_ctrl.sv
// Call/return sequencer: pushes pc+1 on call, pops on ret and issues a
// one-cycle fetch redirect one cycle later while stalling decode.
module call_return_ctrl
    import callstk_pkg::*;
#(
    parameter int unsigned IA_WIDTH = IA_WIDTH_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned SP_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                call_i,
    input  logic                ret_i,
    input  logic [IA_WIDTH-1:0] pc_i,
    input  logic                clear_err_i,
    output logic                mem_we_o,
    output logic [SP_WIDTH-2:0] mem_addr_o,
    output logic [IA_WIDTH-1:0] mem_din_o,
    input  logic [IA_WIDTH-1:0] mem_dout_i,
    output logic                redirect_valid_o,
    output logic [IA_WIDTH-1:0] redirect_addr_o,
    output logic                stall_o,
    output logic                overflow_o,
    output logic                underflow_o,
    output logic [SP_WIDTH-1:0] depth_o
);

    localparam int unsigned AW = SP_WIDTH - 1;

    callstk_state_t      r_state;
    logic                r_overflow;
    logic                r_underflow;

    logic [SP_WIDTH-1:0] w_sp;
    logic [AW-1:0]       w_sp_lo;
    logic [AW-1:0]       w_top_addr;
    logic                w_full;
    logic                w_empty;
    logic                w_idle;
    logic                w_call_only;
    logic                w_ret_only;
    logic                w_both;
    logic                w_do_call;
    logic                w_do_ret;
    logic                w_ovf_set;
    logic                w_unf_set;

    callstk_sp #(
        .DEPTH    (DEPTH),
        .SP_WIDTH (SP_WIDTH)
    ) u_sp (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (w_do_call),
        .dec_i   (w_do_ret),
        .sp_o    (w_sp),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_idle      = (r_state == IDLE);
    assign w_call_only = w_idle &&  call_i && !ret_i;
    assign w_ret_only  = w_idle && !call_i &&  ret_i;
    assign w_both      = w_idle &&  call_i &&  ret_i;
    assign w_do_call   = w_call_only && !w_full;
    assign w_do_ret    = w_ret_only  && !w_empty;
    assign w_ovf_set   = (w_call_only && w_full)  || w_both;
    assign w_unf_set   = (w_ret_only  && w_empty) || w_both;

    // Low bits of sp: at sp==DEPTH they wrap to 0, so minus one still lands on DEPTH-1.
    assign w_sp_lo    = w_sp[AW-1:0];
    assign w_top_addr = w_empty ? '0 : w_sp_lo - AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    r_state <= w_do_ret ? RD_WAIT : IDLE;
                RD_WAIT: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_err_i) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clear_err_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign mem_we_o         = w_do_call;
    assign mem_addr_o       = w_do_call ? w_sp_lo : w_top_addr;
    assign mem_din_o        = w_do_call ? pc_i + IA_WIDTH'(1) : '0;
    assign redirect_valid_o = !w_idle;
    assign redirect_addr_o  = w_idle ? '0 : mem_dout_i;
    assign stall_o          = w_do_ret || !w_idle;
    assign overflow_o       = r_overflow;
    assign underflow_o      = r_underflow;
    assign depth_o          = w_sp;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural synchronous-read
// stack memory; expected values are hand-computed constants.
module tb_call_return_ctrl;

    localparam int unsigned IA_WIDTH = 12;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned SP_WIDTH = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                call_i;
    logic                ret_i;
    logic [IA_WIDTH-1:0] pc_i;
    logic                clear_err_i;
    logic                mem_we_o;
    logic [SP_WIDTH-2:0] mem_addr_o;
    logic [IA_WIDTH-1:0] mem_din_o;
    logic [IA_WIDTH-1:0] mem_dout_i;
    logic                redirect_valid_o;
    logic [IA_WIDTH-1:0] redirect_addr_o;
    logic                stall_o;
    logic                overflow_o;
    logic                underflow_o;
    logic [SP_WIDTH-1:0] depth_o;

    logic [IA_WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    call_return_ctrl #(
        .IA_WIDTH (IA_WIDTH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .call_i           (call_i),
        .ret_i            (ret_i),
        .pc_i             (pc_i),
        .clear_err_i      (clear_err_i),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_din_o        (mem_din_o),
        .mem_dout_i       (mem_dout_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_addr_o  (redirect_addr_o),
        .stall_o          (stall_o),
        .overflow_o       (overflow_o),
        .underflow_o      (underflow_o),
        .depth_o          (depth_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_din_o;
        mem_dout_i <= mem[mem_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_we"},    32'(mem_we_o),         0);
        chk({tag, "_stall"}, 32'(stall_o),          0);
        chk({tag, "_rv"},    32'(redirect_valid_o), 0);
        chk({tag, "_ra"},    32'(redirect_addr_o),  0);
        chk({tag, "_din"},   32'(mem_din_o),        0);
    endtask

    initial begin
        rst_n = 1'b0; call_i = 1'b0; ret_i = 1'b0; pc_i = '0; clear_err_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_depth", 32'(depth_o), 0);
        chk("rst_addr",  32'(mem_addr_o), 0);
        chk("rst_ovf",   32'(overflow_o), 0);
        chk("rst_unf",   32'(underflow_o), 0);
        idle_outputs("rst");
        rst_n = 1'b1;

        // first call
        @(negedge clk); call_i = 1'b1; pc_i = 12'h010; #1;
        chk("c1_we",   32'(mem_we_o), 1);
        chk("c1_addr", 32'(mem_addr_o), 0);
        chk("c1_din",  32'(mem_din_o), 12'h011);
        chk("c1_stall", 32'(stall_o), 0);
        @(negedge clk); call_i = 1'b0; #1;
        chk("c1_depth", 32'(depth_o), 1);
        chk("c1_we_off", 32'(mem_we_o), 0);

        // second call then ret, with a call during RD_WAIT to be ignored
        call_i = 1'b1; pc_i = 12'h020; #1;
        chk("c2_addr", 32'(mem_addr_o), 1);
        chk("c2_din",  32'(mem_din_o), 12'h021);
        @(negedge clk); call_i = 1'b0; #1;
        chk("c2_depth", 32'(depth_o), 2);
        ret_i = 1'b1; #1;
        chk("r1_stall", 32'(stall_o), 1);
        chk("r1_addr",  32'(mem_addr_o), 1);
        chk("r1_we",    32'(mem_we_o), 0);
        chk("r1_rv",    32'(redirect_valid_o), 0);
        @(negedge clk); ret_i = 1'b0; call_i = 1'b1; pc_i = 12'h055; #1;
        chk("r1_rv_n1",   32'(redirect_valid_o), 1);
        chk("r1_ra_n1",   32'(redirect_addr_o), 12'h021);
        chk("r1_stall_n1", 32'(stall_o), 1);
        chk("r1_we_n1",   32'(mem_we_o), 0);
        chk("r1_depth_n1", 32'(depth_o), 1);
        @(negedge clk); call_i = 1'b0; #1;
        chk("r1_stall_n2", 32'(stall_o), 0);
        chk("r1_rv_n2",   32'(redirect_valid_o), 0);
        chk("r1_depth_n2", 32'(depth_o), 1);

        // fill to DEPTH, then overflow
        for (int i = 0; i < 15; i++) begin
            call_i = 1'b1; pc_i = 12'(12'h100 + i);
            @(negedge clk);
        end
        call_i = 1'b0; #1;
        chk("full_depth", 32'(depth_o), DEPTH);
        call_i = 1'b1; pc_i = 12'h300; #1;
        chk("ovf_we",   32'(mem_we_o), 0);
        chk("ovf_addr", 32'(mem_addr_o), 15);
        @(negedge clk); call_i = 1'b0; #1;
        chk("ovf_depth", 32'(depth_o), DEPTH);
        chk("ovf_flag",  32'(overflow_o), 1);
        chk("ovf_unf",   32'(underflow_o), 0);
        clear_err_i = 1'b1;
        @(negedge clk); clear_err_i = 1'b0; #1;
        chk("ovf_clr", 32'(overflow_o), 0);
        clear_err_i = 1'b1; call_i = 1'b1;
        @(negedge clk); clear_err_i = 1'b0; call_i = 1'b0; #1;
        chk("ovf_set_wins", 32'(overflow_o), 1);
        clear_err_i = 1'b1;
        @(negedge clk); clear_err_i = 1'b0;

        // drain the whole stack, checking every return target
        for (int k = 0; k < 16; k++) begin
            ret_i = 1'b1;
            @(negedge clk); ret_i = 1'b0; #1;
            chk($sformatf("drain_ra%0d", k), 32'(redirect_addr_o),
                (k < 15) ? 32'(12'h10F - k) : 32'h011);
            @(negedge clk);
        end
        #1;
        chk("empty_depth", 32'(depth_o), 0);

        // underflow
        ret_i = 1'b1; #1;
        chk("unf_stall", 32'(stall_o), 0);
        chk("unf_addr",  32'(mem_addr_o), 0);
        @(negedge clk); ret_i = 1'b0; #1;
        chk("unf_flag",  32'(underflow_o), 1);
        chk("unf_rv",    32'(redirect_valid_o), 0);
        chk("unf_depth", 32'(depth_o), 0);
        chk("unf_ovf",   32'(overflow_o), 0);
        clear_err_i = 1'b1;
        @(negedge clk); clear_err_i = 1'b0; #1;
        chk("unf_clr", 32'(underflow_o), 0);

        // call and ret together at depth 3
        for (int i = 0; i < 3; i++) begin
            call_i = 1'b1; pc_i = 12'(12'h200 + i);
            @(negedge clk);
        end
        call_i = 1'b1; ret_i = 1'b1; #1;
        chk("both_we",    32'(mem_we_o), 0);
        chk("both_stall", 32'(stall_o), 0);
        @(negedge clk); call_i = 1'b0; ret_i = 1'b0; #1;
        chk("both_depth", 32'(depth_o), 3);
        chk("both_ovf",   32'(overflow_o), 1);
        chk("both_unf",   32'(underflow_o), 1);
        chk("both_rv",    32'(redirect_valid_o), 0);
        clear_err_i = 1'b1;
        @(negedge clk); clear_err_i = 1'b0;

        // pc wrap, then reset in the middle of RD_WAIT
        call_i = 1'b1; pc_i = 12'hFFF; #1;
        chk("wrap_din",  32'(mem_din_o), 0);
        chk("wrap_addr", 32'(mem_addr_o), 3);
        @(negedge clk); call_i = 1'b0; #1;
        chk("wrap_depth", 32'(depth_o), 4);
        ret_i = 1'b1;
        @(negedge clk); ret_i = 1'b0; #1;
        chk("wrap_rv_pre", 32'(redirect_valid_o), 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_depth", 32'(depth_o), 0);
        chk("mid_rst_addr",  32'(mem_addr_o), 0);
        chk("mid_rst_ovf",   32'(overflow_o), 0);
        idle_outputs("mid_rst");
        @(negedge clk); #1;
        chk("mid_rst_rv_hold", 32'(redirect_valid_o), 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_depth", 32'(depth_o), 0);
        chk("post_rst_rv",    32'(redirect_valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
